pll_hdmi_reconf: RTL and testbench

PLL_HDMI_RECONF -- requirements
Module: pll_hdmi_reconf

---
 rtl/pll_hdmi_reconf.sv | 169 ++++++++++++++++
 tb/tb_pll_hdmi_reconf.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_hdmi_reconf.sv
// PLL reconfiguration sequencer for the HDMI pixel clock.
// Captures a divider set on request, then writes M, N, each C counter,
// the fractional word and START to the reconfiguration port. After a
// fixed settle window it waits for lock, bounded by a timeout.
module pll_hdmi_reconf #(
  parameter int NUM_CLK = 1,
  parameter int DIV_W   = 9,
  parameter int FRAC_W  = 32,
  parameter int SETTLE  = 16,
  parameter int TMO_W   = 20
) (
  input  logic                     refclk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [DIV_W-1:0]         cfg_m_div,
  input  logic [DIV_W-1:0]         cfg_n_div,
  input  logic [NUM_CLK*DIV_W-1:0] cfg_c_div,
  input  logic [FRAC_W-1:0]        cfg_frac,
  output logic                     reg_wr,
  output logic [5:0]               reg_addr,
  output logic [31:0]              reg_data,
  input  logic                     reg_wait,
  input  logic                     locked,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WRITE    = 3'd1;
  localparam logic [2:0] S_SETTLE   = 3'd2;
  localparam logic [2:0] S_LOCKWAIT = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  // Write slots: M, N, NUM_CLK C counters, fractional word, START.
  localparam int              NWR       = NUM_CLK + 4;
  localparam logic [3:0]      IDX_LAST  = 4'(NWR - 1);
  localparam logic [3:0]      IDX_FRAC  = 4'(NUM_CLK + 2);
  localparam logic [31:0]     SET_LAST  = 32'(SETTLE - 1);
  // The counter reaches all-ones on the edge that leaves LOCKWAIT.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [2:0]               state;
  logic [3:0]               wr_idx;
  logic [31:0]              settle_cnt;
  logic [TMO_W-1:0]         tmo_cnt;
  logic                     err_q;

  logic [DIV_W-1:0]         m_q;
  logic [DIV_W-1:0]         n_q;
  logic [NUM_CLK*DIV_W-1:0] c_q;
  logic [FRAC_W-1:0]        frac_q;

  logic                     accept;
  logic                     wr_accept;
  logic [4:0]               c_idx;

  // Total divide to counter word; zero means one, saturates at 510.
  // A bypassed counter ignores the odd flag, so it is left clear.
  function automatic logic [17:0] div_word(input logic [DIV_W-1:0] d_in);
    logic [31:0] d;
    logic        byp;
    logic [7:0]  hi;
    d = 32'(d_in);
    if (d == 32'd0) d = 32'd1;
    if (d > 32'd510) d = 32'd510;
    byp = (d == 32'd1);
    hi  = 8'((d + 32'd1) >> 1);
    div_word = {byp, d[0] & ~byp, hi, d[8:1]};
  endfunction

  assign accept    = (state == S_IDLE) && cfg_valid;
  assign wr_accept = (state == S_WRITE) && !reg_wait;

  // Sequencer state, write index, settle and lock-timeout counters.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_idx     <= 4'd0;
      settle_cnt <= 32'd0;
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_WRITE;
            wr_idx <= 4'd0;
            err_q  <= 1'b0;
          end
        end
        S_WRITE: begin
          if (wr_accept) begin
            if (wr_idx == IDX_LAST) begin
              state      <= S_SETTLE;
              settle_cnt <= 32'd0;
            end else begin
              wr_idx <= wr_idx + 4'd1;
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            state   <= S_LOCKWAIT;
            tmo_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 32'd1;
          end
        end
        S_LOCKWAIT: begin
          if (locked) begin
            state <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TMO_LAST) begin
              state <= S_DONE;
              err_q <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request capture; only the accept cycle loads, later changes are ignored.
  always_ff @(posedge refclk) begin
    if (accept) begin
      m_q    <= cfg_m_div;
      n_q    <= cfg_n_div;
      c_q    <= cfg_c_div;
      frac_q <= cfg_frac;
    end
  end

  // Present the current write slot; address and data are zero outside WRITE.
  always_comb begin
    reg_addr = 6'h00;
    reg_data = 32'h0000_0000;
    c_idx    = 5'(wr_idx - 4'd2);
    if (state == S_WRITE) begin
      if (wr_idx == 4'd0) begin
        reg_addr = 6'h04;
        reg_data = {14'd0, div_word(m_q)};
      end else if (wr_idx == 4'd1) begin
        reg_addr = 6'h03;
        reg_data = {14'd0, div_word(n_q)};
      end else if (wr_idx < IDX_FRAC) begin
        reg_addr = 6'h05;
        reg_data = {9'd0, c_idx, div_word(c_q[c_idx*DIV_W +: DIV_W])};
      end else if (wr_idx == IDX_FRAC) begin
        reg_addr = 6'h07;
        reg_data = 32'(frac_q);
      end else begin
        reg_addr = 6'h02;
        reg_data = 32'h0000_0001;
      end
    end
  end

  assign reg_wr    = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign cfg_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_pll_hdmi_reconf.sv
// Bench for pll_hdmi_reconf: a one-counter and a three-counter instance
// share stimulus; a cycle model per instance checks every output.
module tb_pll_hdmi_reconf;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [9:0]  m_in = '0;
  logic [9:0]  n_in = '0;
  logic [8:0]  c_u0 = '0;
  logic [9:0]  c_u1 [3] = '{default: '0};
  logic [31:0] frac_in = '0;
  logic        reg_wait = 1'b0;
  logic        locked = 1'b0;

  logic [1:0]  o_ready, o_wr, o_busy, o_done, o_err;
  logic [5:0]  o_addr [2];
  logic [31:0] o_data [2];

  always #5 refclk = ~refclk;

  pll_hdmi_reconf #(.NUM_CLK(1), .DIV_W(9), .FRAC_W(32), .SETTLE(16), .TMO_W(4)) u0 (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(o_ready[0]),
    .cfg_m_div(m_in[8:0]), .cfg_n_div(n_in[8:0]), .cfg_c_div(c_u0), .cfg_frac(frac_in),
    .reg_wr(o_wr[0]), .reg_addr(o_addr[0]), .reg_data(o_data[0]), .reg_wait(reg_wait),
    .locked(locked), .busy(o_busy[0]), .done(o_done[0]), .err(o_err[0]));

  pll_hdmi_reconf #(.NUM_CLK(3), .DIV_W(10), .FRAC_W(32), .SETTLE(16), .TMO_W(4)) u1 (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(o_ready[1]),
    .cfg_m_div(m_in), .cfg_n_div(n_in), .cfg_c_div({c_u1[2], c_u1[1], c_u1[0]}), .cfg_frac(frac_in),
    .reg_wr(o_wr[1]), .reg_addr(o_addr[1]), .reg_data(o_data[1]), .reg_wait(reg_wait),
    .locked(locked), .busy(o_busy[1]), .done(o_done[1]), .err(o_err[1]));

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  // Reference model: phase 0 idle, 1 writing, 2 settling, 3 awaiting lock, 4 done.
  int ph [2] = '{0, 0};
  int ix [2] = '{0, 0};
  int cnt [2] = '{0, 0};
  bit er [2] = '{1'b0, 1'b0};
  int cm [2], cn [2];
  int cc [2][3];
  logic [31:0] cf [2];

  logic [37:0] wlog0 [$];
  logic [37:0] wlog1 [$];
  int stall_n = 0, wr0 = 0, quiet0 = 0;
  int dcnt [2] = '{0, 0};

  function automatic int numc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int dmask(input int i);
    return (i == 0) ? 511 : 1023;
  endfunction

  function automatic logic [31:0] dword(input int d_raw);
    int d;
    int w;
    d = d_raw;
    if (d == 0) d = 1;
    if (d > 510) d = 510;
    w = ((d + 1) / 2) * 256 + d / 2;
    if (d == 1) w = w + 131072;
    else if (d % 2 == 1) w = w + 65536;
    return 32'(w);
  endfunction

  // Expected {addr, data} of write number n of instance i.
  function automatic logic [37:0] expw(input int i, input int n);
    if (n == 0) return {6'h04, dword(cm[i])};
    if (n == 1) return {6'h03, dword(cn[i])};
    if (n <= numc(i) + 1) return {6'h05, dword(cc[i][n-2]) + 32'((n - 2) * 262144)};
    if (n == numc(i) + 2) return {6'h07, cf[i]};
    return {6'h02, 32'd1};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #2;
  endtask

  // Model update on each rising edge from the inputs the DUT also sees.
  initial begin
    forever begin
      @(posedge refclk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          ph[i] = 0;
          er[i] = 1'b0;
        end else begin
          case (ph[i])
            0: if (cfg_valid) begin
                 ph[i] = 1; ix[i] = 0; er[i] = 1'b0;
                 cm[i] = int'(m_in) & dmask(i);
                 cn[i] = int'(n_in) & dmask(i);
                 cf[i] = frac_in;
                 if (i == 0) cc[0][0] = int'(c_u0);
                 else for (int k = 0; k < 3; k++) cc[1][k] = int'(c_u1[k]);
               end
            1: if (!reg_wait) begin
                 if (ix[i] == numc(i) + 3) begin ph[i] = 2; cnt[i] = 0; end
                 else ix[i] = ix[i] + 1;
               end
            2: if (cnt[i] == 15) begin ph[i] = 3; cnt[i] = 0; end
               else cnt[i] = cnt[i] + 1;
            3: if (locked) ph[i] = 4;
               else if (cnt[i] == 14) begin ph[i] = 4; er[i] = 1'b1; end
               else cnt[i] = cnt[i] + 1;
            default: ph[i] = 0;
          endcase
        end
      end
    end
  end

  // Compare every output of both instances on each falling edge.
  initial begin
    forever begin
      @(negedge refclk);
      if (armed) begin
        for (int i = 0; i < 2; i++) begin
          logic [37:0] w;
          bit wr_e;
          wr_e = (ph[i] == 1);
          w = wr_e ? expw(i, ix[i]) : 38'd0;
          chk($sformatf("u%0d_reg_wr", i), 64'(o_wr[i]), 64'(wr_e));
          chk($sformatf("u%0d_reg_addr", i), 64'(o_addr[i]), 64'(w[37:32]));
          chk($sformatf("u%0d_reg_data", i), 64'(o_data[i]), 64'(w[31:0]));
          chk($sformatf("u%0d_busy", i), 64'(o_busy[i]), 64'(ph[i] != 0));
          chk($sformatf("u%0d_cfg_ready", i), 64'(o_ready[i]), 64'(ph[i] == 0));
          chk($sformatf("u%0d_done", i), 64'(o_done[i]), 64'(ph[i] == 4));
          chk($sformatf("u%0d_err", i), 64'(o_err[i]), 64'(er[i]));
          if (o_done[i]) dcnt[i] = dcnt[i] + 1;
        end
        if (o_wr[0] && !reg_wait) wlog0.push_back({o_addr[0], o_data[0]});
        if (o_wr[1] && !reg_wait) wlog1.push_back({o_addr[1], o_data[1]});
        if (o_wr[0] && o_addr[0] == 6'h03) stall_n = stall_n + 1;
        if (o_wr[0]) wr0 = wr0 + 1;
        if (o_busy[0] && !o_wr[0] && !o_done[0]) quiet0 = quiet0 + 1;
      end
    end
  end

  task automatic clear_stats();
    wlog0.delete(); wlog1.delete();
    stall_n = 0; wr0 = 0; quiet0 = 0;
    dcnt[0] = 0; dcnt[1] = 0;
  endtask

  task automatic request();
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n;
    n = 0;
    while (o_ready !== 2'b11 && n < maxc) begin
      tick();
      n++;
    end
    if (o_ready !== 2'b11) chk({name, "_idle_timeout"}, 64'(o_ready), 64'd3);
    tick();
  endtask

  task automatic wait_u0_addr(input logic [5:0] a, input int maxc, input string name);
    int n;
    n = 0;
    while (!(o_wr[0] === 1'b1 && o_addr[0] === a) && n < maxc) begin
      tick();
      n++;
    end
    if (!(o_wr[0] === 1'b1 && o_addr[0] === a)) chk({name, "_addr_timeout"}, 64'(o_addr[0]), 64'(a));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    armed = 1'b1;
    tick(); tick();
    chk("rst_ready", 64'(o_ready), 64'd3);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_addr0", 64'(o_addr[0]), 64'd0);
    chk("rst_data1", 64'(o_data[1]), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    rst = 1'b0;

    // Nominal programming with lock shortly after settle.
    clear_stats();
    m_in = 10'd12; n_in = 10'd1; frac_in = 32'hE8F5C28F;
    c_u0 = 9'd3; c_u1[0] = 10'd0; c_u1[1] = 10'd7; c_u1[2] = 10'd600;
    request();
    repeat (5 + 16 + 1) tick();
    locked = 1'b1;
    wait_idle(50, "s1");
    locked = 1'b0;
    chk("s1_u0_nwr", 64'(wlog0.size()), 64'd5);
    if (wlog0.size() == 5) begin
      chk("s1_w0", 64'(wlog0[0]), 64'({6'h04, 32'h00000606}));
      chk("s1_w1", 64'(wlog0[1]), 64'({6'h03, 32'h00020100}));
      chk("s1_w2", 64'(wlog0[2]), 64'({6'h05, 32'h00010201}));
      chk("s1_w3", 64'(wlog0[3]), 64'({6'h07, 32'hE8F5C28F}));
      chk("s1_w4", 64'(wlog0[4]), 64'({6'h02, 32'h00000001}));
    end
    chk("s1_u0_wr_cycles", 64'(wr0), 64'd5);
    chk("s1_done_pulses", 64'({dcnt[0][7:0], dcnt[1][7:0]}), 64'h0101);
    chk("s1_u1_nwr", 64'(wlog1.size()), 64'd7);
    if (wlog1.size() == 7) begin
      chk("s3_c0", 64'(wlog1[2][31:0]), 64'h00020100);
      chk("s3_c1", 64'(wlog1[3][31:0]), 64'h00050403);
      chk("s3_c2", 64'(wlog1[4][31:0]), 64'h0008FFFF);
    end

    // Target stall on the N write.
    clear_stats();
    locked = 1'b1;
    m_in = 10'd25; n_in = 10'd4; c_u0 = 9'd10;
    request();
    wait_u0_addr(6'h03, 10, "s2");
    reg_wait = 1'b1;
    tick(); tick(); tick();
    reg_wait = 1'b0;
    tick();
    chk("s2_c_follows", 64'({o_wr[0], o_addr[0]}), 64'({1'b1, 6'h05}));
    wait_idle(60, "s2");
    chk("s2_n_hold_cycles", 64'(stall_n), 64'd4);
    chk("s2_u0_wr_cycles", 64'(wr0), 64'd8);

    // Lock never arrives: timeout after 15 cycles.
    clear_stats();
    locked = 1'b0;
    request();
    wait_idle(80, "s4");
    chk("s4_settle_lock_cycles", 64'(quiet0), 64'd31);
    chk("s4_err_sticky", 64'(o_err), 64'd3);
    request();
    chk("s4_err_cleared", 64'(o_err), 64'd0);

    // Reset during the third write while stalled.
    wait_u0_addr(6'h05, 10, "s5");
    reg_wait = 1'b1;
    rst = 1'b1;
    tick();
    chk("s5_rst_wr", 64'(o_wr), 64'd0);
    chk("s5_rst_busy", 64'(o_busy), 64'd0);
    chk("s5_rst_ready", 64'(o_ready), 64'd3);
    rst = 1'b0;
    reg_wait = 1'b0;
    request();
    chk("s5_restart", 64'({o_wr[0], o_addr[0]}), 64'({1'b1, 6'h04}));
    locked = 1'b1;
    wait_idle(60, "s5");

    // Requests while busy are dropped and do not disturb the captured set.
    clear_stats();
    m_in = 10'd20; n_in = 10'd2; c_u0 = 9'd5;
    request();
    for (int k = 0; k < 20; k++) begin
      cfg_valid = 1'($urandom_range(0, 1));
      m_in = 10'($urandom); n_in = 10'($urandom); c_u0 = 9'($urandom);
      frac_in = $urandom;
      tick();
    end
    cfg_valid = 1'b0;
    wait_idle(60, "s6");
    chk("s6_u0_nwr", 64'(wlog0.size()), 64'd5);
    if (wlog0.size() == 5) chk("s6_m_word", 64'(wlog0[0]), 64'({6'h04, 32'h00000A0A}));

    // Randomized traffic: stalls, lock noise, drops and timeouts.
    for (int it = 0; it < 12; it++) begin
      m_in = 10'($urandom); n_in = 10'($urandom); frac_in = $urandom;
      c_u0 = 9'($urandom);
      for (int k = 0; k < 3; k++) c_u1[k] = 10'($urandom);
      request();
      for (int k = 0; k < 60; k++) begin
        reg_wait = ($urandom_range(0, 2) == 0);
        locked = (it % 3 != 0) && ($urandom_range(0, 7) == 0);
        cfg_valid = ($urandom_range(0, 5) == 0);
        if (cfg_valid) m_in = 10'($urandom);
        tick();
      end
      cfg_valid = 1'b0;
      reg_wait = 1'b0;
      locked = 1'b1;
      wait_idle(120, "rnd");
      locked = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
